// File: rtl/result_pkt_writer.sv
// result_pkt_writer: drains the result FIFO into the PCIe result RAM as data words followed by a length header
module result_pkt_writer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              job_start,
    input  logic [15:0]       result_num,
    input  logic              result_fifo_empty,
    input  logic [DATA_W-1:0] result_fifo_rdat,
    output logic              result_fifo_rden,
    output logic              pcie_ram_wen,
    output logic [ADDR_W-1:0] pcie_ram_waddr,
    output logic [DATA_W-1:0] pcie_ram_wdat,
    output logic              result_write_done,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, DRAIN, WAIT, HDR, DONE} state_t;
    localparam logic [ADDR_W-1:0] HDR_ADDR = ADDR_W'(BASE_ADDR);
    state_t state_q, state_d;
    logic [15:0] num_q, num_d, issued_q, issued_d, written_q, written_d;
    logic rd_vld_q, busy_q, busy_d, done_q, done_d, wen_q, wen_d, start;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    always_comb begin
        start = job_start && !busy_q && state_q == IDLE;
        result_fifo_rden = state_q == DRAIN && !result_fifo_empty && issued_q < num_q;
        num_d = start ? result_num : num_q;
        issued_d = start ? '0 : issued_q + 16'(result_fifo_rden);
        written_d = start ? '0 : written_q + 16'(rd_vld_q);
        wen_d = rd_vld_q || state_q == HDR;
        waddr_d = rd_vld_q ? HDR_ADDR + ADDR_W'(1) + ADDR_W'(written_q) : state_q == HDR ? HDR_ADDR : waddr_q;
        wdat_d = rd_vld_q ? result_fifo_rdat : state_q == HDR ? DATA_W'(num_q) : wdat_q;
        done_d = state_q == DONE;
        busy_d = start ? 1'b1 : done_q ? 1'b0 : busy_q;
        case (state_q)
            IDLE:    state_d = start ? (result_num != '0 ? DRAIN : HDR) : IDLE;
            DRAIN:   state_d = issued_d == num_q ? WAIT : DRAIN;
            WAIT:    state_d = written_d == num_q ? HDR : WAIT;
            HDR:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            num_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            rd_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            issued_q  <= issued_d;
            written_q <= written_d;
            rd_vld_q  <= result_fifo_rden;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdat_q    <= wdat_d;
        end
    end
    assign pcie_ram_wen      = wen_q;
    assign pcie_ram_waddr    = waddr_q;
    assign pcie_ram_wdat     = wdat_q;
    assign result_write_done = done_q;
    assign busy              = busy_q;
endmodule
